// File: rtl/mux_scan_nto1.sv
// mux_scan_nto1: N-channel, W-bit registered multiplexer with manual and
// auto-scan channel selection.
//
// The channel index ch is loaded from sel_manual in manual mode or advanced
// round-robin by a dwell counter in scan mode. The selected word is
// registered onto m one edge after ch, so m always shows the channel that
// ch held before the edge.
//
// Ports:
//   clock      in   system clock, rising edge
//   resetn     in   asynchronous active-low reset
//   mode       in   0 = manual select, 1 = auto-scan
//   hold       in   1 = freeze all state and output (ch_step forced low)
//   sel_manual in   channel index used in manual mode
//   data_in    in   packed channels, channel k = data_in[k*WIDTH +: WIDTH]
//   m          out  registered selected word (lags ch by one edge)
//   ch         out  current channel index (registered)
//   ch_step    out  one-cycle pulse in the first cycle ch holds a new value
//   sel_err    out  last sampled manual select was out of range
module mux_scan_nto1 #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned DWELL    = 8,
    localparam int unsigned SEL_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clock,
    input  logic                      resetn,
    input  logic                      mode,
    input  logic                      hold,
    input  logic [SEL_W-1:0]          sel_manual,
    input  logic [CHANNELS*WIDTH-1:0] data_in,
    output logic [WIDTH-1:0]          m,
    output logic [SEL_W-1:0]          ch,
    output logic                      ch_step,
    output logic                      sel_err
);

    localparam int unsigned CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    // One extra bit so CHANNELS itself is representable for the range check.
    localparam logic [SEL_W:0]   NUM_CH     = (SEL_W+1)'(CHANNELS);
    localparam logic [SEL_W-1:0] LAST_CH    = SEL_W'(CHANNELS - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);

    typedef enum logic [0:0] {
        StManual = 1'b0,
        StScan   = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   ch_q, ch_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic               ch_step_q, ch_step_d;
    logic               sel_err_q, sel_err_d;
    logic [WIDTH-1:0]   chan_word;
    logic               sel_in_range;

    // Word of the channel currently held in ch_q. Indices at or above
    // CHANNELS never match, so non-power-of-two configurations are safe.
    always_comb begin
        chan_word = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (ch_q == SEL_W'(k)) begin
                chan_word = data_in[k*WIDTH +: WIDTH];
            end
        end
    end

    assign sel_in_range = ({1'b0, sel_manual} < NUM_CH);

    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        cnt_d     = cnt_q;
        m_d       = m_q;
        sel_err_d = sel_err_q;
        ch_step_d = 1'b0;

        if (!hold) begin
            state_d = mode ? StScan : StManual;
            m_d     = chan_word;

            if (!mode) begin
                // Manual behaviour also applies on the edge leaving scan, so
                // sel_manual is picked up on the same edge.
                cnt_d = '0;
                if (sel_in_range) begin
                    ch_d      = sel_manual;
                    sel_err_d = 1'b0;
                end else begin
                    sel_err_d = 1'b1;
                end
            end else if (state_q == StManual) begin
                // Edge entering scan: keep ch and start dwelling from zero,
                // so the first advance comes DWELL edges later.
                cnt_d     = '0;
                sel_err_d = 1'b0;
            end else begin
                sel_err_d = 1'b0;
                if (cnt_q == DWELL_LAST) begin
                    cnt_d = '0;
                    ch_d  = (ch_q == LAST_CH) ? '0 : ch_q + SEL_W'(1);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            // Reloading the same manual index is not a step.
            ch_step_d = (ch_d != ch_q);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q   <= StManual;
            ch_q      <= '0;
            cnt_q     <= '0;
            m_q       <= '0;
            ch_step_q <= 1'b0;
            sel_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            cnt_q     <= cnt_d;
            m_q       <= m_d;
            ch_step_q <= ch_step_d;
            sel_err_q <= sel_err_d;
        end
    end

    assign m       = m_q;
    assign ch      = ch_q;
    assign ch_step = ch_step_q;
    assign sel_err = sel_err_q;

    // ch must never leave the valid channel range.
    ch_in_range_a : assert property (@(posedge clock) disable iff (!resetn) ch_q <= LAST_CH);

endmodule

// File: tb/tb_mux_scan_nto1.sv
module tb_mux_scan_nto1;

    logic        clock;
    logic        resetn;

    // DUT A: WIDTH=4, CHANNELS=4, DWELL=3
    logic        mode_a, hold_a;
    logic [1:0]  sel_a;
    logic [15:0] data_a;
    logic [3:0]  m_a;
    logic [1:0]  ch_a;
    logic        step_a, err_a;

    // DUT B: WIDTH=4, CHANNELS=3, DWELL=3
    logic        mode_b, hold_b;
    logic [1:0]  sel_b;
    logic [11:0] data_b;
    logic [3:0]  m_b;
    logic [1:0]  ch_b;
    logic        step_b, err_b;

    int checks = 0;
    int errors = 0;

    mux_scan_nto1 #(.WIDTH(4), .CHANNELS(4), .DWELL(3)) dut_a (
        .clock      (clock),
        .resetn     (resetn),
        .mode       (mode_a),
        .hold       (hold_a),
        .sel_manual (sel_a),
        .data_in    (data_a),
        .m          (m_a),
        .ch         (ch_a),
        .ch_step    (step_a),
        .sel_err    (err_a)
    );

    mux_scan_nto1 #(.WIDTH(4), .CHANNELS(3), .DWELL(3)) dut_b (
        .clock      (clock),
        .resetn     (resetn),
        .mode       (mode_b),
        .hold       (hold_b),
        .sel_manual (sel_b),
        .data_in    (data_b),
        .m          (m_b),
        .ch         (ch_b),
        .ch_step    (step_b),
        .sel_err    (err_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic edge1();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        edge1();
        edge1();
        checks++;
        if (m_a !== 4'h0 || ch_a !== 2'd0 || step_a !== 1'b0 || err_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: m=%h ch=%0d step=%b err=%b, want 0 0 0 0",
                     m_a, ch_a, step_a, err_a);
        end
        resetn = 1'b1;
        sel_a  = 2'd3;
        edge1();
        edge1();
        checks++;
        if (ch_a !== 2'd3 || m_a !== 4'hD) begin
            errors++;
            $display("FAIL pre_reset_load: ch=%0d m=%h, want 3 D", ch_a, m_a);
        end
        // Assert reset mid-cycle; outputs must clear with no clock edge.
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if (m_a !== 4'h0 || ch_a !== 2'd0 || step_a !== 1'b0 || err_a !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: m=%h ch=%0d step=%b err=%b, want 0 0 0 0",
                     m_a, ch_a, step_a, err_a);
        end
        sel_a = 2'd0;
        #2;
        resetn = 1'b1;
    endtask

    task automatic test_manual();
        sel_a = 2'd2;
        edge1();
        checks++;
        if (ch_a !== 2'd2 || step_a !== 1'b1 || m_a !== 4'hA) begin
            errors++;
            $display("FAIL manual_edge1: ch=%0d step=%b m=%h, want 2 1 A", ch_a, step_a, m_a);
        end
        edge1();
        checks++;
        if (ch_a !== 2'd2 || step_a !== 1'b0 || m_a !== 4'hC) begin
            errors++;
            $display("FAIL manual_edge2: ch=%0d step=%b m=%h, want 2 0 C", ch_a, step_a, m_a);
        end
        edge1();
        checks++;
        if (step_a !== 1'b0 || err_a !== 1'b0) begin
            errors++;
            $display("FAIL manual_same_sel: step=%b err=%b, want 0 0", step_a, err_a);
        end
    endtask

    task automatic test_scan();
        logic [1:0] exp_ch   [13] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
        logic [3:0] exp_m    [13] = '{4'hA, 4'hA, 4'hA, 4'hA, 4'hB, 4'hB, 4'hB,
                                      4'hC, 4'hC, 4'hC, 4'hD, 4'hD, 4'hD};
        logic       exp_step [13] = '{0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 1};
        // Return to channel 0 first.
        sel_a = 2'd0;
        edge1();
        edge1();
        checks++;
        if (ch_a !== 2'd0 || step_a !== 1'b0 || m_a !== 4'hA) begin
            errors++;
            $display("FAIL scan_setup: ch=%0d step=%b m=%h, want 0 0 A", ch_a, step_a, m_a);
        end
        mode_a = 1'b1;
        for (int i = 0; i < 13; i++) begin
            edge1();
            checks++;
            if (ch_a !== exp_ch[i] || m_a !== exp_m[i] || step_a !== exp_step[i]
                || err_a !== 1'b0) begin
                errors++;
                $display("FAIL scan_seq[%0d]: ch=%0d m=%h step=%b err=%b, want %0d %h %b 0",
                         i, ch_a, m_a, step_a, err_a, exp_ch[i], exp_m[i], exp_step[i]);
            end
        end
    endtask

    task automatic test_hold();
        // From ch=0, cnt=0: four edges reach ch=1 with counter=1.
        for (int i = 0; i < 4; i++) edge1();
        checks++;
        if (ch_a !== 2'd1 || m_a !== 4'hB || step_a !== 1'b0) begin
            errors++;
            $display("FAIL hold_setup: ch=%0d m=%h step=%b, want 1 B 0", ch_a, m_a, step_a);
        end
        hold_a = 1'b1;
        for (int i = 0; i < 5; i++) begin
            edge1();
            checks++;
            if (ch_a !== 2'd1 || m_a !== 4'hB || step_a !== 1'b0) begin
                errors++;
                $display("FAIL hold_frozen[%0d]: ch=%0d m=%h step=%b, want 1 B 0",
                         i, ch_a, m_a, step_a);
            end
        end
        hold_a = 1'b0;
        edge1();
        checks++;
        if (ch_a !== 2'd1 || step_a !== 1'b0) begin
            errors++;
            $display("FAIL hold_release1: ch=%0d step=%b, want 1 0", ch_a, step_a);
        end
        edge1();
        checks++;
        if (ch_a !== 2'd2 || step_a !== 1'b1 || m_a !== 4'hB) begin
            errors++;
            $display("FAIL hold_release2: ch=%0d step=%b m=%h, want 2 1 B", ch_a, step_a, m_a);
        end
    endtask

    task automatic test_mode_switch();
        logic [1:0] exp_ch   [4] = '{1, 1, 1, 2};
        logic       exp_step [4] = '{0, 0, 0, 1};
        // ch=2, counter=0: three edges reach ch=3.
        for (int i = 0; i < 3; i++) edge1();
        checks++;
        if (ch_a !== 2'd3 || step_a !== 1'b1) begin
            errors++;
            $display("FAIL switch_setup: ch=%0d step=%b, want 3 1", ch_a, step_a);
        end
        mode_a = 1'b0;
        sel_a  = 2'd1;
        edge1();
        checks++;
        if (ch_a !== 2'd1 || step_a !== 1'b1 || m_a !== 4'hD) begin
            errors++;
            $display("FAIL switch_to_manual: ch=%0d step=%b m=%h, want 1 1 D", ch_a, step_a, m_a);
        end
        mode_a = 1'b1;
        for (int i = 0; i < 4; i++) begin
            edge1();
            checks++;
            if (ch_a !== exp_ch[i] || step_a !== exp_step[i]) begin
                errors++;
                $display("FAIL switch_to_scan[%0d]: ch=%0d step=%b, want %0d %b",
                         i, ch_a, step_a, exp_ch[i], exp_step[i]);
            end
        end
    endtask

    task automatic test_out_of_range();
        logic [1:0] exp_ch   [7] = '{1, 1, 1, 2, 2, 2, 0};
        logic       exp_step [7] = '{0, 0, 0, 1, 0, 0, 1};
        sel_b = 2'd2;
        edge1();
        edge1();
        checks++;
        if (ch_b !== 2'd2 || err_b !== 1'b0 || m_b !== 4'hC) begin
            errors++;
            $display("FAIL oor_setup: ch=%0d err=%b m=%h, want 2 0 C", ch_b, err_b, m_b);
        end
        sel_b = 2'd3;
        edge1();
        checks++;
        if (ch_b !== 2'd2 || err_b !== 1'b1 || step_b !== 1'b0) begin
            errors++;
            $display("FAIL oor_sel3: ch=%0d err=%b step=%b, want 2 1 0", ch_b, err_b, step_b);
        end
        edge1();
        checks++;
        if (ch_b !== 2'd2 || err_b !== 1'b1) begin
            errors++;
            $display("FAIL oor_sel3_held: ch=%0d err=%b, want 2 1", ch_b, err_b);
        end
        sel_b = 2'd1;
        edge1();
        checks++;
        if (ch_b !== 2'd1 || err_b !== 1'b0 || step_b !== 1'b1) begin
            errors++;
            $display("FAIL oor_recover: ch=%0d err=%b step=%b, want 1 0 1", ch_b, err_b, step_b);
        end
        mode_b = 1'b1;
        for (int i = 0; i < 7; i++) begin
            edge1();
            checks++;
            if (ch_b !== exp_ch[i] || step_b !== exp_step[i]) begin
                errors++;
                $display("FAIL oor_scan_wrap[%0d]: ch=%0d step=%b, want %0d %b",
                         i, ch_b, step_b, exp_ch[i], exp_step[i]);
            end
        end
        checks++;
        if (m_b !== 4'hC) begin
            errors++;
            $display("FAIL oor_scan_m: m=%h, want C", m_b);
        end
    endtask

    initial begin
        resetn = 1'b0;
        mode_a = 1'b0;
        hold_a = 1'b0;
        sel_a  = 2'd0;
        data_a = {4'hD, 4'hC, 4'hB, 4'hA};
        mode_b = 1'b0;
        hold_b = 1'b0;
        sel_b  = 2'd0;
        data_b = {4'hC, 4'hB, 4'hA};

        test_reset();
        test_manual();
        test_scan();
        test_hold();
        test_mode_switch();
        test_out_of_range();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_scan_nto1.md
Name: mux_scan_nto1

Overview:
- Parametrised N-channel, W-bit registered multiplexer. It is the successor to the team's gate-level 2-to-1 mux.
- Adds a registered output and two select modes:
  - Manual: the channel is taken from the select input.
  - Auto-scan: a round-robin sequencer steps through the channels, dwelling a fixed number of cycles on each.
- Sits between the board switch inputs and the LEDR/HEX display logic. It lets one display path show several input words in turn.

Parameters:
- WIDTH, 4, bits per channel.
- CHANNELS, 4, number of input channels (>=2).
- DWELL, 8, clock cycles spent on each channel in scan mode (>=1).
- SEL_W (localparam), max(1, clog2(CHANNELS)), channel index width.

Ports:
- clock  in  1  system clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- mode  in  1  0 = manual select, 1 = auto-scan.
- hold  in  1  1 = freeze all state and output.
- sel_manual  in  SEL_W  channel index used in manual mode.
- data_in  in  CHANNELS*WIDTH  packed inputs; channel k = data_in[k*WIDTH +: WIDTH].
- m  out  WIDTH  registered selected word.
- ch  out  SEL_W  current channel index (registered).
- ch_step  out  1  one-cycle pulse, high in the first cycle ch holds a new value.
- sel_err  out  1  high while the last manual select sampled was out of range.

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous and active-low on resetn. Nothing is clocked while resetn=0.
- Reset values:
  - FSM = S_MANUAL
  - ch = 0
  - dwell counter = 0
  - m = 0
  - ch_step = 0
  - sel_err = 0
- Exiting reset: the first rising edge after resetn goes high behaves as a normal edge.
- FSM has two states, S_MANUAL and S_SCAN. The next state equals mode, sampled at each edge where hold=0.
- Output path:
  - At every edge with hold=0, m <= slice(ch), using the pre-edge value of ch.
  - So m lags ch by exactly one cycle. Data changes on the current channel appear on m one edge later.
- S_MANUAL (and the edge entering it):
  - If sel_manual < CHANNELS: ch <= sel_manual and sel_err <= 0.
  - Otherwise: ch holds its value and sel_err <= 1.
  - The dwell counter is held at 0.
- S_SCAN:
  - The dwell counter increments each edge.
  - When the counter is at DWELL-1, it resets to 0 and ch advances to ch+1, wrapping CHANNELS-1 -> 0.
  - With DWELL=1, ch advances every edge.
  - sel_err <= 0. sel_manual is ignored.
- Manual -> scan transition:
  - The scan starts from the current ch with the counter at 0.
  - The first advance occurs DWELL edges after the edge at which the FSM entered S_SCAN.
- Scan -> manual transition: ch loads sel_manual (if in range) on the same edge the FSM enters S_MANUAL.
- ch_step:
  - Registered. It is 1 for exactly one cycle after any edge where ch changed value, otherwise 0.
  - A manual select that reloads the same value does not pulse.
- hold=1 takes priority over everything:
  - FSM, ch, counter, m and sel_err keep their values.
  - ch_step <= 0.
  - Mode changes during hold take effect at the first edge with hold=0.
- Non-power-of-2 CHANNELS: the wrap occurs at CHANNELS-1, so ch never reaches an index >= CHANNELS.
- Reset mid-scan: everything returns to the reset values immediately (asynchronous). After release, operation restarts in S_MANUAL.
- Latency summary:
  - mode/sel_manual to ch: 1 edge.
  - ch to m: 1 edge.
  - Scan period: DWELL*CHANNELS cycles.

Test Plan (WIDTH=4, CHANNELS=4, DWELL=3; data_in = {4'hD,4'hC,4'hB,4'hA}, i.e. channel 0 = A):
- Reset: drive resetn=0 mid-cycle -> m=0, ch=0, ch_step=0, sel_err=0 immediately, without waiting for a clock edge.
- Manual mode:
  - mode=0, sel_manual=2 -> ch=2 after edge 1 with ch_step=1 for one cycle; m=4'hC after edge 2.
  - Then sel_manual=2 held -> no further ch_step.
- Scan mode:
  - mode=1 from ch=0 -> ch sequence 0,0,0,1,1,1,2,2,2,3,3,3,0 on successive edges.
  - ch_step pulses every 3 cycles; m follows A,B,C,D one edge behind ch; wrap 3->0 is observed.
- Hold: hold=1 for 5 cycles while ch=1 with counter=1 -> ch, m and counter are frozen and ch_step=0.
  - After release, ch advances to 2 exactly 2 edges later.
- Out-of-range select: use the CHANNELS=3 configuration. mode=0, sel_manual=3 -> sel_err=1 and ch is unchanged.
  - Then sel_manual=1 -> sel_err=0 and ch=1. In scan mode, the sequence wraps 2->0.
- Mode switch: in scan with ch=3, set mode=0 with sel_manual=1 -> ch=1 on the next edge with ch_step=1.
  - Then mode=1 -> the first advance to 2 occurs 3 edges later.
